inst_buffer: RTL and testbench
==============================

# inst_buffer

Circular FIFO of `IF_ID_PACKET` entries between the instruction fetch stage and `dispatch`. It accepts one fetched instruction per cycle and presents the oldest held instruction to `dispatch`. It retires that instruction only when dispatch does not stall, which decouples fetch from ROB and reservation-station back-pressure. On a squash, such as a branch mispredict, all buffered instructions are discarded in a single cycle.

## Interface
Parameters:
- `DEPTH`, default 8: number of entries. Must be a power of two and at least 2.

Ports:
- `clock`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `squash`  in  1: flush all entries, such as on a branch mispredict.
- `if_packet`  in  IF_ID_PACKET: instruction from fetch. Only entries with `valid=1` are candidates for enqueue.
- `dispatch_stall`  in  1: the `stall` output of `dispatch`. While high, the head entry is not consumed.
- `if_id_packet`  out  IF_ID_PACKET: head entry, presented to `dispatch`.
- `full`  out  1: buffer holds `DEPTH` entries. Fetch must hold its PC while this is high.
- `count`  out  $clog2(DEPTH+1): number of occupied entries.

## Operation
- **Storage:** `DEPTH` packet registers, with `head` and `tail` pointers of $clog2(DEPTH) bits each. Pointers wrap naturally from `DEPTH-1` to 0.
- **Full and empty:** decided by `count`, not by pointer equality. `full` is `count==DEPTH`. Empty is `count==0`.
- **Push condition:** `if_packet.valid & ~full & ~squash`.
- **Push action:** write `if_packet` at `tail`, then increment `tail`.
- **Fullness is registered:** `full` reflects `count` at the start of the cycle. A push is refused when full even if a pop occurs in the same cycle. There is no full-bypass.
- **Pop condition:** `count!=0 & ~dispatch_stall & ~squash`.
- **Pop action:** increment `head`.
- **Simultaneous push and pop:** both happen, `count` is unchanged, and the pointers still advance. When `count==0`, a simultaneous push and pop can only push. The pop condition is false because the buffer has no bypass.
- **Head output when not empty:** `if_id_packet` is the entry at `head`, with its stored `valid=1`.
- **Head output when empty:** `if_id_packet` carries `valid=0`, `inst=`NOP``, `PC=0` and `NPC=0`.
- **Head output is independent of `dispatch_stall`:** `dispatch` masks validity itself.
- **Squash:**
  - Next state: `head=tail=0` and `count=0`.
  - Any push or pop requested in the same cycle is ignored.
  - Entry contents need not be cleared, because the empty output forces `valid=0`.
- **Reset:** identical to squash. Reset overrides everything.
- **Invalid input:** an `if_packet` with `valid=0` is never stored, regardless of space.
- **Count update:** `count` increments by 1 on push only, decrements by 1 on pop only, and is unchanged otherwise. It never exceeds `DEPTH` and never underflows.

## Timing
- **Reset values:**
  - `count=0`, `full=0`.
  - `if_id_packet.valid=0`, with `inst=`NOP``, `PC=0`, `NPC=0`.
  - Internal pointers are 0.
- **Enqueue latency:** a packet pushed in cycle N is visible on `if_id_packet` in cycle N+1 at the earliest. The path from `if_packet` to `if_id_packet` is never combinational.
- **Throughput:** one push and one pop per cycle, so sustained single-issue throughput is 1 instruction per cycle after one cycle of fill.
- **Output timing:** `if_id_packet`, `full` and `count` are functions of registered state only. `if_id_packet` is a mux of the entry array at `head`.
- **Pop timing:** `dispatch_stall` is sampled at the edge. A head entry held while `dispatch_stall=1` is still at the head, unchanged, in the next cycle.
- **Squash timing:** squash asserted in cycle N gives an empty buffer in cycle N+1. The first post-squash push is accepted in cycle N+1.
- **Ordering:** strict FIFO order is preserved across pointer wrap-around.

## Test plan
- **Reset, then single instruction:**
  - Stimulus: reset, then push one packet with `PC=0x100` and `dispatch_stall=0`.
  - Required response: in the cycle after the push, `if_id_packet.PC=0x100`, `valid=1` and `count=1`. In the following cycle, `count=0` and `valid=0`.
- **Fill to full:**
  - Stimulus: `dispatch_stall=1` and 10 consecutive valid pushes with PCs 0x0, 0x4, …
  - Required response:
    - `count` reaches 8 and `full=1`.
    - Pushes 9 and 10 are dropped.
    - The head stays at `PC=0x0` throughout.
- **Drain after full:**
  - Stimulus: from the full state, release `dispatch_stall`.
  - Required response:
    - PCs 0x0 through 0x1C appear in order on 8 consecutive cycles.
    - `full` deasserts after the first pop.
    - `count` then reads 0.
- **Steady-state push and pop with wrap-around:**
  - Stimulus: 20 cycles of simultaneous push and pop, starting from `count=3`.
  - Required response:
    - `count` stays at 3.
    - The output PC sequence equals the input sequence delayed by 3 entries.
    - The pointers wrap without loss.
- **Squash mid-stream:**
  - Stimulus: `count=5`, then assert `squash` together with a valid push of `PC=0x200`.
  - Required response:
    - Next cycle: `count=0` and `valid=0`. The 0x200 packet is not stored.
    - A push in that next cycle appears at the head in the cycle after.
- **Invalid input and reset precedence:**
  - Stimulus: push with `if_packet.valid=0`, then assert `reset` together with `squash` and a push at `count=4`.
  - Required response:
    - The invalid packet leaves `count` unchanged.
    - After reset, `count=0`, `full=0` and `if_id_packet.inst=`NOP``.

Source files
------------

// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and dispatch: a circular FIFO of IF_ID packets
// with single-cycle squash and a registered, non-bypassing head output.
package inst_buffer_pkg;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] NPC;
        logic [31:0] PC;
    } IF_ID_PACKET;
endpackage

module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       squash,
    input  IF_ID_PACKET                if_packet,
    input  logic                       dispatch_stall,
    output IF_ID_PACKET                if_id_packet,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    IF_ID_PACKET          mem_q [DEPTH];
    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 empty;
    logic                 push;
    logic                 pop;

    // Push: fetch offers valid, taken when not full (full is the registered
    // "not ready"). Pop: head is valid when non-empty, taken when dispatch
    // does not stall. Squash cancels both in the same cycle.
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign push  = if_packet.valid & ~full & ~squash;
    assign pop   = ~empty & ~dispatch_stall & ~squash;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = tail_q + PW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || squash) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry contents need no reset: an empty buffer never exposes them.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem_q[tail_q] <= if_packet;
        end
    end

    always_comb begin
        if (empty) begin
            if_id_packet       = '0;
            if_id_packet.inst  = NOP;
        end else begin
            if_id_packet       = mem_q[head_q];
            if_id_packet.valid = 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: reset, fill/drain, wrap-around streaming,
// squash and reset precedence, checked with immediate assertions.
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam int DEPTH = 8;

    logic        clock;
    logic        reset;
    logic        squash;
    IF_ID_PACKET if_packet;
    logic        dispatch_stall;
    IF_ID_PACKET if_id_packet;
    logic        full;
    logic [3:0]  count;

    int n_checks;
    int n_fail;
    logic [31:0] exp_q[$];

    inst_buffer #(.DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .squash         (squash),
        .if_packet      (if_packet),
        .dispatch_stall (dispatch_stall),
        .if_id_packet   (if_id_packet),
        .full           (full),
        .count          (count)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        if_packet.valid = v;
        if_packet.PC    = pc;
        if_packet.NPC   = pc + 32'd4;
        if_packet.inst  = 32'hA000_0000 | pc;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        squash   = 1'b0;
        dispatch_stall = 1'b0;
        drive(1'b0, 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // reset state
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_valid", 32'(if_id_packet.valid), 32'd0);
        check("rst_inst", if_id_packet.inst, NOP);
        check("rst_pc", if_id_packet.PC, 32'h0);
        check("rst_npc", if_id_packet.NPC, 32'h0);

        // single instruction: not visible combinationally, then one cycle later
        drive(1'b1, 32'h100);
        check("single_nobypass_valid", 32'(if_id_packet.valid), 32'd0);
        tick();
        drive(1'b0, 32'h0);
        check("single_pc", if_id_packet.PC, 32'h100);
        check("single_npc", if_id_packet.NPC, 32'h104);
        check("single_inst", if_id_packet.inst, 32'hA000_0100);
        check("single_valid", 32'(if_id_packet.valid), 32'd1);
        check("single_count", 32'(count), 32'd1);
        tick();
        check("single_drained_count", 32'(count), 32'd0);
        check("single_drained_valid", 32'(if_id_packet.valid), 32'd0);

        // fill to full with stall; pushes 9 and 10 dropped
        dispatch_stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(4 * i));
            tick();
            check("fill_count", 32'(count), (i < DEPTH) ? 32'(i + 1) : 32'(DEPTH));
            check("fill_head_pc", if_id_packet.PC, 32'h0);
        end
        check("fill_full", 32'(full), 32'd1);

        // drain in order
        drive(1'b0, 32'h0);
        dispatch_stall = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            check("drain_pc", if_id_packet.PC, 32'(4 * k));
            check("drain_valid", 32'(if_id_packet.valid), 32'd1);
            tick();
            if (k == 0) begin
                check("drain_full_drop", 32'(full), 32'd0);
                check("drain_count7", 32'(count), 32'd7);
            end
        end
        check("drain_empty_count", 32'(count), 32'd0);
        check("drain_empty_valid", 32'(if_id_packet.valid), 32'd0);

        // prefill to 3, then 20 cycles of push+pop (scoreboard order)
        dispatch_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i));
            exp_q.push_back(32'h300 + 32'(4 * i));
            tick();
        end
        check("stream_pre_count", 32'(count), 32'd3);
        dispatch_stall = 1'b0;
        for (int j = 0; j < 20; j++) begin
            drive(1'b1, 32'h400 + 32'(4 * j));
            exp_q.push_back(32'h400 + 32'(4 * j));
            check("stream_head_pc", if_id_packet.PC, exp_q[0]);
            void'(exp_q.pop_front());
            tick();
            check("stream_count", 32'(count), 32'd3);
        end
        check("stream_tail_head", if_id_packet.PC, exp_q[0]);

        // grow to 5, then squash with a simultaneous push of 0x200
        dispatch_stall = 1'b1;
        drive(1'b1, 32'h480);
        tick();
        drive(1'b1, 32'h484);
        tick();
        check("sq_pre_count", 32'(count), 32'd5);
        squash = 1'b1;
        drive(1'b1, 32'h200);
        tick();
        squash = 1'b0;
        exp_q.delete();
        check("sq_count", 32'(count), 32'd0);
        check("sq_valid", 32'(if_id_packet.valid), 32'd0);
        drive(1'b1, 32'h500);
        tick();
        check("sq_post_pc", if_id_packet.PC, 32'h500);
        check("sq_post_count", 32'(count), 32'd1);

        // invalid packet ignored, then reset beats squash and push
        drive(1'b0, 32'h600);
        tick();
        check("inv_count", 32'(count), 32'd1);
        check("inv_head_pc", if_id_packet.PC, 32'h500);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h700 + 32'(4 * i));
            tick();
        end
        check("rp_pre_count", 32'(count), 32'd4);
        reset  = 1'b1;
        squash = 1'b1;
        drive(1'b1, 32'h800);
        tick();
        reset  = 1'b0;
        squash = 1'b0;
        drive(1'b0, 32'h0);
        check("rp_count", 32'(count), 32'd0);
        check("rp_full", 32'(full), 32'd0);
        check("rp_inst", if_id_packet.inst, NOP);
        check("rp_valid", 32'(if_id_packet.valid), 32'd0);
        tick();
        check("rp_hold_count", 32'(count), 32'd0);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
